mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle MIPS-subset control unit. It is the producer of the 3-bit alu_ctrl code that the existing 32-bit alu consumes.
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. It drives datapath mux selects and write enables.
- ALU function decode is combinational from alu_op and funct, and is delivered to the alu in the same cycle.

Parameters:
- none (opcodes, funct codes and state encodings are fixed constants in the shared include)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  alu zero flag
- pc_en  out  1  PC register enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU out
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction register load
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback select: 0 = ALU out, 1 = mem data
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALU out, 10 = jump target
- alu_ctrl  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt
- state_o  out  4  current state (debug)

Behaviour:
- States: FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), MEMWB(4), MEMWR(5), RTYPEEX(6), RTYPEWB(7), BEQEX(8), ADDIEX(9), ADDIWB(10), JEX(11).
- Reset, asynchronous: state goes to FETCH immediately.
- While reset is high:
  - pc_en, ir_write, mem_write and reg_write are forced to 0.
  - All other outputs hold their FETCH values.
- Reset asserted mid-instruction abandons the instruction; no partial write occurs after assertion.
- Transitions:
  - FETCH→DECODE, always.
  - DECODE:
    - lw(100011) / sw(101011) → MEMADR
    - R-type(000000) → RTYPEEX
    - beq(000100) → BEQEX
    - addi(001000) → ADDIEX
    - j(000010) → JEX
    - any other op → FETCH (treated as a nop)
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD→MEMWB.
  - RTYPEEX→RTYPEWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX → FETCH.
- Instruction latencies (cycles including fetch): lw 5; sw 4; R 4; addi 4; beq 3; j 3; unknown op 2.
- Outputs are Moore, decoded from state. Every signal not listed for a state is 0.
  - FETCH: ir_write=1, pc_en=1, alu_src_b=01, alu_op=00.
  - DECODE: alu_src_b=11, alu_op=00. This computes the branch target.
  - MEMADR, ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: i_or_d=1.
  - MEMWR: i_or_d=1, mem_write=1.
  - MEMWB: reg_write=1, mem_to_reg=1.
  - RTYPEEX: alu_src_a=1, alu_op=10.
  - RTYPEWB: reg_dst=1, reg_write=1.
  - ADDIWB: reg_write=1.
  - BEQEX: alu_src_a=1, alu_op=01, pc_src=01. Internal branch=1; pc_en = branch & zero. zero is sampled combinationally in this same cycle.
  - JEX: pc_src=10, pc_en=1.
- alu_ctrl decode:
  - alu_op 00 → 010.
  - alu_op 01 → 110.
  - alu_op 1x → by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Unrecognised funct → 010 (add); reg_write still occurs.
- alu_ctrl is a combinational function of state and funct only; no extra latency.

Optional Feature:
- Macro MC_BNE_EN.
- Defined:
  - DECODE with op 000101 → new state BNEEX(12).
  - BNEEX outputs match BEQEX, except pc_en = branch & ~zero. BNEEX→FETCH.
- Undefined: op 000101 is an unknown op (DECODE→FETCH); state 12 is unreachable.

Decomposition:
- Shared include mc_defs.vh holds:
  - state encodings S_FETCH..S_BNEEX
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE
  - funct constants
  - alu_ctrl codes ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
- One sub-module, mc_alu_decoder: combinational, (alu_op, funct) → alu_ctrl.
- The FSM lives in mc_controller.

Test Plan:
- Reset held 2 cycles, then released with op=100011 (lw) → state_o sequence 0,1,2,3,4,0. Checks:
  - reg_write=1 and mem_to_reg=1 only in state 4.
  - pc_en=0 and ir_write=0 during reset.
- op=000000, funct=101010 → in RTYPEEX alu_ctrl=111. In RTYPEWB reg_dst=1 and reg_write=1. Back to FETCH after 4 cycles.
- op=000100 (beq):
  - zero=1 in BEQEX → pc_en=1, pc_src=01.
  - Repeated with zero=0 → pc_en=0.
- op=101011 (sw) → mem_write=1 for exactly one cycle in MEMWR with i_or_d=1; reg_write never asserts.
- op=111111 (unknown) → FETCH, DECODE, FETCH; no write enable asserted except FETCH's pc_en/ir_write. Then reset is pulsed mid-cycle during MEMRD of a lw → state_o=0 immediately and reg_write stays 0.
- With MC_BNE_EN defined: op=000101, zero=0 → state 12, pc_en=1. Without the macro: state returns 1→0.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared constants for the multicycle MIPS-subset controller: state encodings,
// opcodes, funct codes, alu_ctrl codes and the internal alu_op classes.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // alu_op classes: 1x means "look at funct"
  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle. master = controller side, slave = datapath side.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic       i_or_d;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state_o;

  modport master (
    input  op, funct, zero,
    output pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, alu_ctrl, state_o
  );

  modport slave (
    output op, funct, zero,
    input  pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, alu_ctrl, state_o
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU function decode: (alu_op, funct) -> 3-bit alu_ctrl.
module mc_alu_decoder
  import mc_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    if (alu_op[1]) begin
      // unknown funct falls back to add; the writeback still happens
      case (funct)
        FN_ADD:  alu_ctrl = ALU_ADD;
        FN_SUB:  alu_ctrl = ALU_SUB;
        FN_AND:  alu_ctrl = ALU_AND;
        FN_OR:   alu_ctrl = ALU_OR;
        FN_SLT:  alu_ctrl = ALU_SLT;
        default: alu_ctrl = ALU_ADD;
      endcase
    end else if (alu_op[0]) begin
      alu_ctrl = ALU_SUB;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM (Moore) driving datapath selects/enables.
// Optional bne support is enabled by defining MC_BNE_EN.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);

  state_t     state, state_next;
  logic [1:0] alu_op;
  logic       pc_write, branch, branch_ne;
  logic       ir_write_s, mem_write_s, reg_write_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_next = S_BNEEX;
`endif
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_next = S_MEMWB;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write       = 1'b0;
    branch         = 1'b0;
    branch_ne      = 1'b0;
    ir_write_s     = 1'b0;
    mem_write_s    = 1'b0;
    reg_write_s    = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_src     = 2'b00;
    alu_op         = AOP_ADD;
    case (state)
      S_FETCH: begin
        ir_write_s    = 1'b1;
        pc_write      = 1'b1;
        bus.alu_src_b = 2'b01;
      end
      // PC + (imm<<2): branch target parked in ALU out
      S_DECODE: bus.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEMRD: bus.i_or_d = 1'b1;
      S_MEMWR: begin
        bus.i_or_d  = 1'b1;
        mem_write_s = 1'b1;
      end
      S_MEMWB: begin
        reg_write_s    = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_RTYPEEX: begin
        bus.alu_src_a = 1'b1;
        alu_op        = AOP_FUNCT;
      end
      S_RTYPEWB: begin
        bus.reg_dst = 1'b1;
        reg_write_s = 1'b1;
      end
      S_ADDIWB: reg_write_s = 1'b1;
      S_BEQEX: begin
        bus.alu_src_a = 1'b1;
        alu_op        = AOP_SUB;
        bus.pc_src    = 2'b01;
        branch        = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        bus.alu_src_a = 1'b1;
        alu_op        = AOP_SUB;
        bus.pc_src    = 2'b01;
        branch_ne     = 1'b1;
      end
`endif
      S_JEX: begin
        bus.pc_src = 2'b10;
        pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by reset so nothing is written while it is held.
  assign bus.pc_en     = (pc_write | (branch & bus.zero) | (branch_ne & ~bus.zero)) & ~reset;
  assign bus.ir_write  = ir_write_s  & ~reset;
  assign bus.mem_write = mem_write_s & ~reset;
  assign bus.reg_write = reg_write_s & ~reset;
  assign bus.state_o   = state;

  mc_alu_decoder u_alu_dec (
    .alu_op   (alu_op),
    .funct    (bus.funct),
    .alu_ctrl (bus.alu_ctrl)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: expected per-cycle output vectors are
// queued when an instruction is driven and compared each cycle on the falling edge.
module tb_mc_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  obs_t sb_q[$];

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.st = bus.state_o;         o.pc_en = bus.pc_en;
    o.i_or_d = bus.i_or_d;      o.mem_write = bus.mem_write;
    o.ir_write = bus.ir_write;  o.reg_dst = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg; o.reg_write = bus.reg_write;
    o.alu_src_a = bus.alu_src_a;   o.alu_src_b = bus.alu_src_b;
    o.pc_src = bus.pc_src;      o.alu_ctrl = bus.alu_ctrl;
    return o;
  endfunction

  // Expected outputs per state, straight from the state/output table.
  function automatic obs_t expect_for(input logic [3:0] st, input logic [5:0] f, input logic z);
    obs_t e = '0;
    e.st = st;
    e.alu_ctrl = 3'b010;
    case (st)
      4'd0:  begin e.ir_write = 1; e.pc_en = 1; e.alu_src_b = 2'b01; end
      4'd1:  e.alu_src_b = 2'b11;
      4'd2, 4'd9: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      4'd3:  e.i_or_d = 1;
      4'd4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      4'd5:  begin e.i_or_d = 1; e.mem_write = 1; end
      4'd6: begin
        e.alu_src_a = 1;
        case (f)
          6'b100010: e.alu_ctrl = 3'b110;
          6'b100100: e.alu_ctrl = 3'b000;
          6'b100101: e.alu_ctrl = 3'b001;
          6'b101010: e.alu_ctrl = 3'b111;
          default:   e.alu_ctrl = 3'b010;
        endcase
      end
      4'd7:  begin e.reg_dst = 1; e.reg_write = 1; end
      4'd10: e.reg_write = 1;
      4'd8:  begin e.alu_src_a = 1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01; e.pc_en = z; end
      4'd12: begin e.alu_src_a = 1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01; e.pc_en = ~z; end
      4'd11: begin e.pc_src = 2'b10; e.pc_en = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t expect_reset();
    obs_t e = expect_for(4'd0, 6'd0, 1'b0);
    e.pc_en = 0;
    e.ir_write = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (state got %0d expected %0d)",
               tag, got, exp, got.st, exp.st);
    end
  endtask

  // Called on a falling edge with the FSM in FETCH; returns on the falling edge
  // after the instruction's last state.
  task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int n, input logic [19:0] seq);
    obs_t e;
    bus.op = o; bus.funct = f; bus.zero = z;
    for (int i = 0; i < n; i++) sb_q.push_back(expect_for(seq[4*i +: 4], f, z));
    for (int i = 0; i < n; i++) begin
      #1;
      e = sb_q.pop_front();
      chk($sformatf("%s[%0d]", tag, i), observe(), e);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.op = 6'b100011; bus.funct = 6'd0; bus.zero = 1'b1;
    @(negedge clk); #1 chk("reset_c0", observe(), expect_reset());
    @(negedge clk); #1 chk("reset_c1", observe(), expect_reset());
    @(negedge clk); reset = 1'b0;

    run_instr("lw",      6'b100011, 6'b101010, 1'b1, 5, 20'h43210);
    run_instr("r_slt",   6'b000000, 6'b101010, 1'b0, 4, 20'h07610);
    run_instr("r_sub",   6'b000000, 6'b100010, 1'b1, 4, 20'h07610);
    run_instr("r_and",   6'b000000, 6'b100100, 1'b0, 4, 20'h07610);
    run_instr("r_or",    6'b000000, 6'b100101, 1'b0, 4, 20'h07610);
    run_instr("r_add",   6'b000000, 6'b100000, 1'b0, 4, 20'h07610);
    run_instr("r_badfn", 6'b000000, 6'b000111, 1'b0, 4, 20'h07610);
    run_instr("beq_z1",  6'b000100, 6'b101010, 1'b1, 3, 20'h00810);
    run_instr("beq_z0",  6'b000100, 6'b101010, 1'b0, 3, 20'h00810);
    run_instr("sw",      6'b101011, 6'b000000, 1'b0, 4, 20'h05210);
    run_instr("addi",    6'b001000, 6'b101010, 1'b1, 4, 20'h0a910);
    run_instr("j",       6'b000010, 6'b000000, 1'b0, 3, 20'h00b10);
    run_instr("unknown", 6'b111111, 6'b000000, 1'b0, 2, 20'h00010);
`ifdef MC_BNE_EN
    run_instr("bne_z0",  6'b000101, 6'b000000, 1'b0, 3, 20'h00c10);
    run_instr("bne_z1",  6'b000101, 6'b000000, 1'b1, 3, 20'h00c10);
`else
    run_instr("bne_off", 6'b000101, 6'b000000, 1'b0, 2, 20'h00010);
`endif

    // Abort a lw in MEMRD: reset mid-cycle must return to FETCH at once
    run_instr("lw_abort", 6'b100011, 6'b000000, 1'b0, 3, 20'h00210);
    #1 chk("abort_memrd", observe(), expect_for(4'd3, 6'd0, 1'b0));
    #1 reset = 1'b1;
    #1 chk("abort_async", observe(), expect_reset());
    @(negedge clk); #1 chk("abort_hold", observe(), expect_reset());
    @(negedge clk); reset = 1'b0;

    run_instr("lw_after", 6'b100011, 6'b000000, 1'b0, 5, 20'h43210);
    #1 chk("final_fetch", observe(), expect_for(4'd0, 6'd0, 1'b0));

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
